// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, registers the fetched word into ir,
// and issues it to decode over valid/ready, applying branch redirects from execute.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter logic [31:0] PROG_END  = 32'd80,
   parameter logic [31:0] MEM_BYTES = 32'd512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_offset,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] ir_pc_q;
   logic        ir_valid_q;
   logic        done_q;
   logic        err_q;
   logic [15:0] count_q;

   logic        pc_legal;
   logic [31:0] pc_plus4;
   logic [31:0] target_d;
   logic        target_bad;
   logic [15:0] count_d;

   // The word at PROG_END is never issued; anything at or past MEM_BYTES is off the end.
   assign pc_legal   = (pc_q != PROG_END) && (pc_q < MEM_BYTES);
   assign pc_plus4   = pc_q + 32'd4;
   assign target_d   = ir_pc_q + 32'd4 + redirect_offset;
   assign target_bad = (target_d[1:0] != 2'b00) || (target_d >= MEM_BYTES);
   assign count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   // NOTE: every register below is assigned with <= so all updates in a state
   // see the pre-edge values (e.g. ir_pc_q <= pc_q and pc_q <= pc_plus4 together).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= 32'd0;
         ir_pc_q    <= 32'd0;
         ir_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         count_q    <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  pc_q    <= RESET_PC;
                  state_q <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (!pc_legal) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  ir_q       <= imem_data;
                  ir_pc_q    <= pc_q;
                  ir_valid_q <= 1'b1;
                  pc_q       <= pc_plus4;
                  count_q    <= count_d;
                  state_q    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (ir_ready) begin
                  if (redirect) begin
                     ir_valid_q <= 1'b0;
                     if (target_bad) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        // One bubble: the target is fetched in the next FETCH cycle.
                        pc_q    <= target_d;
                        state_q <= S_FETCH;
                     end
                  end else if (pc_legal) begin
                     ir_q    <= imem_data;
                     ir_pc_q <= pc_q;
                     pc_q    <= pc_plus4;
                     count_q <= count_d;
                  end else begin
                     ir_valid_q <= 1'b0;
                     done_q     <= 1'b1;
                     state_q    <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  count_q <= 16'd0;
                  pc_q    <= RESET_PC;
                  state_q <= S_FETCH;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign imem_addr   = pc_q;
   assign ir          = ir_q;
   assign ir_pc       = ir_pc_q;
   assign ir_valid    = ir_valid_q;
   assign busy        = (state_q == S_FETCH) || (state_q == S_HOLD);
   assign done        = done_q;
   assign err         = err_q;
   assign fetch_count = count_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the single-issue teaching processor.
- Owns the program counter, drives the address of the combinational instruction memory, and holds the fetched word in an instruction register.
- Hands each instruction to decode over a valid/ready handshake and applies taken-branch redirects from execute.
- Stops at a fixed end-of-program address, or when a redirect target is illegal.

Parameters:
- RESET_PC, 0, PC loaded on reset and on every start.
- PROG_END, 80, byte address that terminates fetch; the word at this address is never issued.
- MEM_BYTES, 512, instruction memory size in bytes; legal PCs are below this value.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins fetching from RESET_PC; honoured in IDLE and DONE only.
- imem_addr  out  32  byte address to instruction memory; combinationally equal to pc.
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- ir  out  32  registered instruction.
- ir_pc  out  32  address from which ir was fetched.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir this cycle.
- redirect  in  1  branch taken for the instruction currently in ir.
- redirect_offset  in  32  sign-extended byte offset; target = ir_pc + 4 + redirect_offset.
- busy  out  1  state is FETCH or HOLD.
- done  out  1  program ended (normal or error), held until start.
- err  out  1  ended on an illegal redirect target.
- fetch_count  out  16  instructions issued since start, saturating at 0xFFFF.

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, done=0, err=0, fetch_count=0.
- States are IDLE, FETCH, HOLD and DONE. imem_addr = pc in every state.
- IDLE:
  - start -> pc<=RESET_PC, FETCH.
- FETCH:
  - If pc==PROG_END or pc>=MEM_BYTES: go to DONE with done<=1; ir_valid stays 0.
  - Otherwise: ir<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+4, fetch_count++, go to HOLD.
  - Latency: start pulse to first ir_valid is 2 cycles.
- HOLD (ir_valid=1):
  - ir_ready=0: all registers hold; redirect is ignored; ir is stable.
  - ir_ready=1, redirect=0, pc is legal: load the next word the same cycle (ir<=imem_data, ir_pc<=pc, pc<=pc+4, count++) and stay in HOLD. Throughput is 1 instruction per cycle.
  - ir_ready=1, redirect=0, pc==PROG_END or pc>=MEM_BYTES: ir_valid<=0, done<=1, go to DONE.
  - ir_ready=1, redirect=1: compute target = ir_pc+4+redirect_offset (32-bit, modulo 2^32).
    - If target[1:0]!=0 or target>=MEM_BYTES: ir_valid<=0, err<=1, done<=1, go to DONE.
    - Else: pc<=target, ir_valid<=0, go to FETCH. This costs exactly one bubble cycle.
- DONE:
  - done=1, busy=0, ir_valid=0; pc, ir and count hold.
  - start -> done<=0, err<=0, fetch_count<=0, pc<=RESET_PC, go to FETCH.
- start in FETCH or HOLD is ignored.
- Reset mid-fetch immediately drops ir_valid. No instruction is issued after rst falls until a new start.
- A redirect target equal to PROG_END is legal; it ends normally (err=0) on the following FETCH.
- fetch_count does not wrap: it holds at 0xFFFF.

Test Plan:
- Straight line, 20-word program (addresses 0..76), ir_ready tied to 1, no redirects -> ir_pc steps 0,4,...,76 on consecutive cycles after the first; done rises the cycle after 76 is accepted; fetch_count=20; err=0.
- Backpressure: hold ir_ready=0 for 3 cycles while ir_pc=8 -> ir, ir_pc and ir_valid are unchanged for those 3 cycles; pc stays 12; no increment of fetch_count.
- Backward redirect: at ir_pc=52, pulse ir_ready=1, redirect=1, offset=-32 -> next issued ir_pc=24 after exactly one cycle with ir_valid=0. Forward redirect: at ir_pc=24, offset=36 -> next issued ir_pc=64.
- Illegal target: at ir_pc=8, offset=2 -> err=1, done=1, ir_valid=0 the next cycle. Separately, at ir_pc=60, offset=1000 -> err=1.
- Redirect to end: at ir_pc=68, offset=8 (target 80) -> FETCH, then done=1 with err=0; no word is issued from address 80.
- Reset mid-run: assert rst asynchronously between edges while ir_pc=32 -> ir_valid, done and count read 0 immediately. After release, start gives first ir_pc=0 two cycles later.
